// File: rtl/control_multiciclo.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back,
// counts retired instructions and halts on the halt opcode. Define ILLEGAL_TRAP_EN to trap illegal opcodes.
module control_multiciclo #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [2:0]       uc,
  output logic [3:0]       estado,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_I_EXEC    = 4'd10;
  localparam logic [3:0] S_I_WB      = 4'd11;
  localparam logic [3:0] S_HALT      = 4'd12;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  // The branch decision itself happens in the datapath (zero & pc_write_cond).
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_I_EXEC;
          OP_HALT:      state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = S_HALT;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:  state_d = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // An instruction retires whenever control returns to FETCH from elsewhere.
  always_comb begin
    count_d = count_q;
    if (state_q != S_FETCH && state_d == S_FETCH) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d, illegal_op;

  always_comb begin
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT: illegal_op = 1'b0;
      default:                                            illegal_op = 1'b1;
    endcase
    illegal_d = illegal_q | ((state_q == S_DECODE) & illegal_op);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal = illegal_q & ~rst;
`else
  assign illegal = 1'b0;
`endif

  // Controls are decoded from the state; reset forces every output low at once.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    uc            = 3'b000;
    halted        = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          uc        = 3'b001;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          uc        = 3'b001;
        end
        S_MEM_ADDR, S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          uc        = 3'b001;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          uc        = 3'b111;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          uc            = 3'b010;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_I_WB:  reg_write = 1'b1;
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign estado      = rst ? S_FETCH : state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Randomized self-checking bench for control_multiciclo: builds the expected state/cycle
// sequence of each instruction from its opcode and memory wait counts, then checks every cycle.
module tb_control_multiciclo;

  localparam int CNT_W = 16;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic clk = 1'b0;
  logic rst, zero, mem_ready;
  logic [5:0] op;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, halted, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] uc;
  logic [3:0] estado;
  logic [CNT_W-1:0] instr_count;

  control_multiciclo #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .uc(uc), .estado(estado), .halted(halted), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;
  bit exp_ill = 1'b0;
  int plan_st[$];
  bit plan_mr[$];

  logic [17:0] ctrl_obs;
  assign ctrl_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                     uc, halted};

  // Control word each state must present, straight from the state table.
  function automatic logic [17:0] expCtrl(input int st, input bit mr);
    logic pw, pwc, iod, mr_o, mw, irw, m2r, rd, rw, asa, hl;
    logic [1:0] asb, psrc;
    logic [2:0] u;
    {pw, pwc, iod, mr_o, mw, irw, m2r, rd, rw, asa, hl} = '0;
    asb = 2'b00; psrc = 2'b00; u = 3'b000;
    case (st)
      0:  begin mr_o = 1; asb = 2'b01; u = 3'b001; irw = mr; pw = mr; end
      1:  begin asb = 2'b11; u = 3'b001; end
      2:  begin asa = 1; asb = 2'b10; u = 3'b001; end
      3:  begin mr_o = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; u = 3'b111; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; u = 3'b010; pwc = 1; psrc = 2'b01; end
      9:  begin pw = 1; psrc = 2'b10; end
      10: begin asa = 1; asb = 2'b10; u = 3'b001; end
      11: rw = 1;
      12: hl = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mr_o, mw, irw, m2r, rd, rw, asa, asb, psrc, u, hl};
  endfunction

  function automatic bit isLegal(input logic [5:0] o);
    return (o == OP_R) || (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) ||
           (o == OP_ADDI) || (o == OP_J) || (o == OP_HALT);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] randOp();
    return 6'($urandom_range(63, 0));
  endfunction

  // One clock: drive inputs on the falling edge, check settled outputs just after.
  task automatic stepCheck(input int st, input bit mr, input logic [5:0] opv);
    @(negedge clk);
    mem_ready = mr;
    op        = opv;
    zero      = 1'($urandom_range(1, 0));
    #1;
    checkOutput($sformatf("estado_s%0d", st), 32'(estado), 32'(st));
    checkOutput($sformatf("ctrl_s%0d", st), 32'(ctrl_obs), 32'(expCtrl(st, mr)));
    checkOutput("instr_count", 32'(instr_count), 32'(exp_cnt));
    checkOutput("illegal", 32'(illegal), 32'(exp_ill));
  endtask

  // Expected state trace of one instruction given its fetch and memory wait cycles.
  task automatic applyStimulus(input logic [5:0] opv, input int wf, input int wm);
    bit retires;
    plan_st.delete();
    plan_mr.delete();
    retires = 1'b1;
    repeat (wf) begin plan_st.push_back(0); plan_mr.push_back(1'b0); end
    plan_st.push_back(0); plan_mr.push_back(1'b1);
    plan_st.push_back(1); plan_mr.push_back(1'($urandom_range(1, 0)));
    case (opv)
      OP_R:    begin plan_st.push_back(6); plan_st.push_back(7); end
      OP_BEQ:  plan_st.push_back(8);
      OP_J:    plan_st.push_back(9);
      OP_ADDI: begin plan_st.push_back(10); plan_st.push_back(11); end
      OP_HALT: begin plan_st.push_back(12); retires = 1'b0; end
      OP_LW, OP_SW: plan_st.push_back(2);
      default: begin
`ifdef ILLEGAL_TRAP_EN
        plan_st.push_back(12);
        retires = 1'b0;
`endif
      end
    endcase
    while (plan_mr.size() < plan_st.size()) plan_mr.push_back(1'($urandom_range(1, 0)));
    if (opv == OP_LW || opv == OP_SW) begin
      repeat (wm) begin plan_st.push_back(opv == OP_LW ? 3 : 5); plan_mr.push_back(1'b0); end
      plan_st.push_back(opv == OP_LW ? 3 : 5); plan_mr.push_back(1'b1);
      if (opv == OP_LW) begin plan_st.push_back(4); plan_mr.push_back(1'($urandom_range(1, 0))); end
    end
    foreach (plan_st[i]) begin
      if (plan_st[i] == 12 && !isLegal(opv)) exp_ill = 1'b1;
      stepCheck(plan_st[i], plan_mr[i], (plan_st[i] == 0) ? randOp() : opv);
    end
    if (retires) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    op = randOp();
    exp_cnt = 0;
    exp_ill = 1'b0;
    repeat (2) begin
      #1;
      checkOutput("rst_ctrl", 32'(ctrl_obs), 32'd0);
      checkOutput("rst_estado", 32'(estado), 32'd0);
      checkOutput("rst_count", 32'(instr_count), 32'd0);
      checkOutput("rst_illegal", 32'(illegal), 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    checkOutput("post_rst_estado", 32'(estado), 32'd0);
    checkOutput("post_rst_ctrl", 32'(ctrl_obs), 32'(expCtrl(0, 1'b0)));
  endtask

  initial begin
    logic [5:0] legal_ops [6];
    logic [5:0] rop;
    legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    rst = 1'b1;
    zero = 1'b0;
    mem_ready = 1'b0;
    op = 6'd0;
    doReset();

    applyStimulus(OP_R, 0, 0);
    applyStimulus(OP_LW, 0, 2);
    applyStimulus(OP_BEQ, 0, 0);
    applyStimulus(OP_J, 0, 0);
    applyStimulus(OP_SW, 1, 1);
    applyStimulus(OP_ADDI, 2, 0);

    for (int n = 0; n < 150; n++) begin
      rop = legal_ops[$urandom_range(5, 0)];
`ifndef ILLEGAL_TRAP_EN
      if ($urandom_range(9, 0) == 0) begin
        do rop = randOp(); while (isLegal(rop));
      end
`endif
      applyStimulus(rop, $urandom_range(2, 0), $urandom_range(3, 0));
    end

    stepCheck(0, 1'b1, randOp());
    stepCheck(1, 1'b1, OP_LW);
    stepCheck(2, 1'b1, OP_LW);
    stepCheck(3, 1'b0, OP_LW);
    doReset();
    applyStimulus(OP_R, 0, 0);

    applyStimulus(6'b111110, 0, 0);
`ifdef ILLEGAL_TRAP_EN
    repeat (5) stepCheck(12, 1'($urandom_range(1, 0)), randOp());
    doReset();
`endif
    applyStimulus(OP_BEQ, 0, 0);

    applyStimulus(OP_HALT, 1, 0);
    repeat (20) stepCheck(12, 1'($urandom_range(1, 0)), randOp());
    doReset();
    applyStimulus(OP_J, 0, 0);
    stepCheck(0, 1'b0, randOp());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multi-cycle main control unit for the MIPS datapath. A Moore/Mealy state machine sequences instruction fetch, decode, execute, memory access and write-back over several clocks, and drives the datapath multiplexer selects, register/memory strobes and the 3-bit `uc` ALU-operation code consumed by the ALU control block. It waits on a memory ready handshake, counts retired instructions, and halts on a `halt` opcode.

## Interface
- `CNT_W`, 16, width of retired-instruction counter
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `op`  in  6  opcode field from instruction register (valid from DECODE onward)
- `zero`  in  1  ALU zero flag (used by datapath with `pc_write_cond`)
- `mem_ready`  in  1  memory completes current read/write this cycle
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each  datapath controls
- `alu_src_b`  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `pc_source`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `uc`  out  3  ALU op: 001 add, 010 sub, 111 R-type (funct decoded downstream)
- `estado`  out  4  current state code
- `halted`  out  1  high in HALT
- `illegal`  out  1  illegal-opcode flag (see Configuration)
- `instr_count`  out  CNT_W  retired instructions

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010, halt 111111; all others illegal.
- States (code): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, HALT 12.
- Outputs not listed per state are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, uc=001, pc_source=00; ir_write=pc_write=mem_ready (Mealy). Stay until mem_ready, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, uc=001. Next: lw/sw→MEM_ADDR, R→R_EXEC, beq→BRANCH, j→JUMP, addi→I_EXEC, halt→HALT, illegal→per Configuration.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, uc=001; lw→MEM_READ, sw→MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; hold until mem_ready → FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, uc=111 → R_WB: reg_write=1, reg_dst=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, uc=010, pc_write_cond=1, pc_source=01 → FETCH.
- JUMP: pc_write=1, pc_source=10 → FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, uc=001 → I_WB: reg_write=1, reg_dst=0 → FETCH.
- HALT: halted=1, all strobes 0; stays until rst.
- instr_count increments by 1 on every transition into FETCH from any non-FETCH state; wraps at 2^CNT_W−1 → 0.

## Timing
- Reset: state FETCH, instr_count 0, illegal 0; while rst high all outputs forced 0 (asynchronously), estado=0.
- Reset mid-instruction aborts it; first FETCH after rst release; no count.
- Zero-wait cycles per instruction: beq 3, j 3, R 4, addi 4, sw 4, lw 5; each mem_ready=0 cycle in FETCH/MEM_READ/MEM_WRITE adds 1.
- mem_ready ignored outside FETCH, MEM_READ, MEM_WRITE.
- Strobes are single-cycle except mem_read/mem_write, held through wait states.
- op sampled only in DECODE and MEM_ADDR; must be stable those cycles.

## Configuration
- `ILLEGAL_TRAP_EN` defined: illegal opcode in DECODE → HALT; illegal=1 sticky until rst; no count.
- Undefined: illegal opcode treated as NOP, DECODE → FETCH, counted as retired; illegal tied 0.

## Test plan
- rst pulse mid-MEM_READ → all outputs 0 during rst, estado=0, instr_count=0, FETCH after release.
- R-type, mem_ready=1 always → states 0,1,6,7,0; uc=111 in R_EXEC; reg_write & reg_dst in R_WB; instr_count 0→1.
- lw with mem_ready low 2 cycles in MEM_READ → mem_read held 3 cycles, total 7 cycles, mem_to_reg=1 in MEM_WB.
- beq → 3 cycles, BRANCH shows uc=010, pc_write_cond=1, pc_source=01; j → pc_write=1, pc_source=10.
- op=111111 → HALT, halted=1, stays 20 cycles, instr_count unchanged.
- op=111110: with ILLEGAL_TRAP_EN → HALT, illegal=1; without → FETCH next cycle, count+1, illegal=0.
